// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - request/write-port bundle for regfile_write_arbiter
interface regfile_write_arbiter_if #(
   parameter int P_NUM_REQ    = 4,
   parameter int P_DATA_WIDTH = 16,
   parameter int P_ADDR_WIDTH = 4
);
   localparam int LP_GW   = $clog2(P_NUM_REQ);
   localparam int LP_NREG = 2 ** P_ADDR_WIDTH;

   logic                              I_HOLD;
   logic [P_NUM_REQ-1:0]              I_REQ_VALID;
   logic [P_NUM_REQ-1:0]              I_REQ_LOCK;
   logic [P_NUM_REQ*P_ADDR_WIDTH-1:0] I_REQ_ADDR;
   logic [P_NUM_REQ*P_DATA_WIDTH-1:0] I_REQ_DATA;
   logic [P_NUM_REQ-1:0]              O_REQ_READY;
   logic [LP_NREG-1:0]                O_WR_EN;
   logic [P_ADDR_WIDTH-1:0]           O_WR_ADDR;
   logic [P_DATA_WIDTH-1:0]           O_WR_DATA;
   logic [LP_GW-1:0]                  O_GRANT_ID;
   logic                              O_LOCKED;

   modport master (
      output I_HOLD, I_REQ_VALID, I_REQ_LOCK, I_REQ_ADDR, I_REQ_DATA,
      input  O_REQ_READY, O_WR_EN, O_WR_ADDR, O_WR_DATA, O_GRANT_ID, O_LOCKED
   );

   modport slave (
      input  I_HOLD, I_REQ_VALID, I_REQ_LOCK, I_REQ_ADDR, I_REQ_DATA,
      output O_REQ_READY, O_WR_EN, O_WR_ADDR, O_WR_DATA, O_GRANT_ID, O_LOCKED
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter with lock mode for the register-file write port
module regfile_write_arbiter #(
   parameter int P_NUM_REQ    = 4,
   parameter int P_DATA_WIDTH = 16,
   parameter int P_ADDR_WIDTH = 4
) (
   input logic                    I_CLK,
   input logic                    I_RESET,
   regfile_write_arbiter_if.slave bus
);
   localparam int LP_GW   = $clog2(P_NUM_REQ);
   localparam int LP_NREG = 2 ** P_ADDR_WIDTH;

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]              r_state;
   logic [LP_GW-1:0]        r_ptr;
   logic [LP_GW-1:0]        r_owner;
   logic [LP_NREG-1:0]      r_wr_en;
   logic [P_ADDR_WIDTH-1:0] r_wr_addr;
   logic [P_DATA_WIDTH-1:0] r_wr_data;
   logic [LP_GW-1:0]        r_grant_id;

   logic                    w_found;
   logic [LP_GW-1:0]        w_win;
   logic [LP_GW:0]          w_c;
   logic [P_NUM_REQ-1:0]    w_ready;
   logic                    w_xfer;
   logic [LP_GW-1:0]        w_sel;
   logic [LP_GW-1:0]        w_ptr_next;
   logic [P_ADDR_WIDTH-1:0] w_sel_addr;
   logic [P_DATA_WIDTH-1:0] w_sel_data;
   logic                    w_sel_lock;

   // Scan pointer, pointer+1, ... with wrap; first valid requester wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_c     = '0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
         w_c = {1'b0, r_ptr} + (LP_GW+1)'(k);
         if (w_c >= (LP_GW+1)'(P_NUM_REQ))
            w_c = w_c - (LP_GW+1)'(P_NUM_REQ);
         if (!w_found && bus.I_REQ_VALID[w_c[LP_GW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_c[LP_GW-1:0];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (!I_RESET && !bus.I_HOLD) begin
         if (r_state == ST_LOCKED)
            w_ready[r_owner] = 1'b1;
         else if (w_found)
            w_ready[w_win] = 1'b1;
      end
   end

   assign w_sel      = (r_state == ST_LOCKED) ? r_owner : w_win;
   assign w_xfer     = |(bus.I_REQ_VALID & w_ready);
   assign w_ptr_next = (w_sel == LP_GW'(P_NUM_REQ-1)) ? '0 : w_sel + LP_GW'(1);

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_lock = 1'b0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
         if (LP_GW'(k) == w_sel) begin
            w_sel_addr = bus.I_REQ_ADDR[k*P_ADDR_WIDTH +: P_ADDR_WIDTH];
            w_sel_data = bus.I_REQ_DATA[k*P_DATA_WIDTH +: P_DATA_WIDTH];
            w_sel_lock = bus.I_REQ_LOCK[k];
         end
      end
   end

   // Idle cycles only clear the enable; address, data and grant keep the last write.
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_state    <= ST_ARB;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_wr_en    <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_grant_id <= '0;
      end else if (w_xfer) begin
         r_state    <= w_sel_lock ? ST_LOCKED : ST_ARB;
         r_ptr      <= w_ptr_next;
         r_owner    <= w_sel;
         r_wr_en    <= LP_NREG'(1) << w_sel_addr;
         r_wr_addr  <= w_sel_addr;
         r_wr_data  <= w_sel_data;
         r_grant_id <= w_sel;
      end else begin
         r_wr_en    <= '0;
      end
   end

   assign bus.O_REQ_READY = w_ready;
   assign bus.O_WR_EN     = r_wr_en;
   assign bus.O_WR_ADDR   = r_wr_addr;
   assign bus.O_WR_DATA   = r_wr_data;
   assign bus.O_GRANT_ID  = r_grant_id;
   assign bus.O_LOCKED    = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.P_NUM_REQ(4), .P_DATA_WIDTH(16), .P_ADDR_WIDTH(4)) bus4 ();
   regfile_write_arbiter_if #(.P_NUM_REQ(3), .P_DATA_WIDTH(16), .P_ADDR_WIDTH(4)) bus3 ();

   regfile_write_arbiter #(.P_NUM_REQ(4), .P_DATA_WIDTH(16), .P_ADDR_WIDTH(4)) u_dut4 (
      .I_CLK(clk), .I_RESET(rst), .bus(bus4)
   );
   regfile_write_arbiter #(.P_NUM_REQ(3), .P_DATA_WIDTH(16), .P_ADDR_WIDTH(4)) u_dut3 (
      .I_CLK(clk), .I_RESET(rst), .bus(bus3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #3;
   endtask

   task automatic req4(input int i, input bit v, input bit lk, input logic [3:0] a, input logic [15:0] d);
      bus4.I_REQ_VALID[i]       = v;
      bus4.I_REQ_LOCK[i]        = lk;
      bus4.I_REQ_ADDR[i*4 +: 4]   = a;
      bus4.I_REQ_DATA[i*16 +: 16] = d;
   endtask

   task automatic req3(input int i, input bit v, input logic [3:0] a, input logic [15:0] d);
      bus3.I_REQ_VALID[i]       = v;
      bus3.I_REQ_ADDR[i*4 +: 4]   = a;
      bus3.I_REQ_DATA[i*16 +: 16] = d;
   endtask

   // Reference model: pointer/owner/lock kept as plain integers, checked just before each rising edge.
   initial begin : model
      int           m_ptr, m_owner, g, c;
      bit           m_lk;
      logic [15:0]  e_en, e_data;
      logic [3:0]   e_addr, x_rdy;
      logic [1:0]   e_gid;
      m_ptr = 0; m_owner = 0; m_lk = 0;
      e_en = '0; e_data = '0; e_addr = '0; e_gid = '0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            m_ptr = 0; m_owner = 0; m_lk = 0;
            e_en = '0; e_data = '0; e_addr = '0; e_gid = '0;
         end
         chk("m_wr_en", 32'(bus4.O_WR_EN), 32'(e_en));
         chk("m_wr_addr", 32'(bus4.O_WR_ADDR), 32'(e_addr));
         chk("m_wr_data", 32'(bus4.O_WR_DATA), 32'(e_data));
         chk("m_grant_id", 32'(bus4.O_GRANT_ID), 32'(e_gid));
         chk("m_locked", 32'(bus4.O_LOCKED), 32'(m_lk));
         x_rdy = '0;
         if (!rst && !bus4.I_HOLD) begin
            if (m_lk) x_rdy = 4'(1 << m_owner);
            else begin
               for (int k = 0; k < 4; k++) begin
                  c = (m_ptr + k) % 4;
                  if (x_rdy == 0 && bus4.I_REQ_VALID[c]) x_rdy = 4'(1 << c);
               end
            end
         end
         chk("m_ready", 32'(bus4.O_REQ_READY), 32'(x_rdy));
         if (!rst) begin
            g = -1;
            for (int i = 0; i < 4; i++)
               if (bus4.I_REQ_VALID[i] && x_rdy[i]) g = i;
            if (g >= 0) begin
               e_addr  = bus4.I_REQ_ADDR[g*4 +: 4];
               e_data  = bus4.I_REQ_DATA[g*16 +: 16];
               e_en    = 16'(1) << e_addr;
               e_gid   = 2'(g);
               m_ptr   = (g + 1) % 4;
               m_owner = g;
               m_lk    = bus4.I_REQ_LOCK[g];
            end else begin
               e_en = '0;
            end
         end
      end
   end

   initial begin : stim
      rst = 1'b1;
      bus4.I_HOLD = 1'b0; bus4.I_REQ_VALID = '0; bus4.I_REQ_LOCK = '0;
      bus4.I_REQ_ADDR = '0; bus4.I_REQ_DATA = '0;
      bus3.I_HOLD = 1'b0; bus3.I_REQ_VALID = '0; bus3.I_REQ_LOCK = '0;
      bus3.I_REQ_ADDR = '0; bus3.I_REQ_DATA = '0;
      for (int i = 0; i < 4; i++) req4(i, 1'b1, 1'b0, 4'(4 + i), 16'hA000 + 16'(i));

      // reset state, requests present but no ready
      cyc(); cyc(); #1;
      chk("rst_ready", 32'(bus4.O_REQ_READY), 32'h0);
      chk("rst_wr_en", 32'(bus4.O_WR_EN), 32'h0);
      chk("rst_locked", 32'(bus4.O_LOCKED), 32'h0);
      rst = 1'b0;
      bus4.I_REQ_VALID = '0;

      // single write from req1
      cyc();
      req4(1, 1'b1, 1'b0, 4'd3, 16'hBEEF);
      #1 chk("single_ready", 32'(bus4.O_REQ_READY), 32'h2);
      cyc();
      bus4.I_REQ_VALID = '0;
      #1;
      chk("single_en", 32'(bus4.O_WR_EN), 32'h0008);
      chk("single_data", 32'(bus4.O_WR_DATA), 32'hBEEF);
      chk("single_gid", 32'(bus4.O_GRANT_ID), 32'd1);

      // pointer is 2; only req0 valid wraps around
      cyc();
      req4(0, 1'b1, 1'b0, 4'd2, 16'h1234);
      #1 chk("wrap_ready", 32'(bus4.O_REQ_READY), 32'h1);
      cyc();
      bus4.I_REQ_VALID = '0;
      #1 chk("pre_rst_en", 32'(bus4.O_WR_EN), 32'h0004);

      // asynchronous reset mid-cycle
      rst = 1'b1;
      for (int i = 0; i < 4; i++) req4(i, 1'b1, 1'b0, 4'(4 + i), 16'hA000 + 16'(i));
      #2;
      chk("async_en", 32'(bus4.O_WR_EN), 32'h0);
      chk("async_addr", 32'(bus4.O_WR_ADDR), 32'h0);
      chk("async_data", 32'(bus4.O_WR_DATA), 32'h0);
      chk("async_gid", 32'(bus4.O_GRANT_ID), 32'h0);
      chk("async_ready", 32'(bus4.O_REQ_READY), 32'h0);
      cyc();
      rst = 1'b0;

      // round robin from reset: 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_ready", 32'(bus4.O_REQ_READY), 32'(1 << (k % 4)));
         if (k > 0) begin
            chk("rr_gid", 32'(bus4.O_GRANT_ID), 32'((k - 1) % 4));
            chk("rr_en", 32'(bus4.O_WR_EN), 32'(1 << (4 + (k - 1) % 4)));
         end
         cyc();
      end
      #1;
      chk("rr_gid_last", 32'(bus4.O_GRANT_ID), 32'd0);
      chk("rr_en_last", 32'(bus4.O_WR_EN), 32'h0010);

      // hold for three cycles
      bus4.I_HOLD = 1'b1;
      repeat (3) begin
         cyc(); #1;
         chk("hold_ready", 32'(bus4.O_REQ_READY), 32'h0);
         chk("hold_en", 32'(bus4.O_WR_EN), 32'h0);
      end
      bus4.I_HOLD = 1'b0;
      #1 chk("hold_resume_ready", 32'(bus4.O_REQ_READY), 32'h2);
      cyc(); #1;
      chk("hold_resume_gid", 32'(bus4.O_GRANT_ID), 32'd1);
      chk("hold_resume_en", 32'(bus4.O_WR_EN), 32'h0020);

      // lock: req2 takes ownership while req0 waits
      bus4.I_REQ_VALID = '0;
      req4(0, 1'b1, 1'b0, 4'd4, 16'hA000);
      req4(2, 1'b1, 1'b1, 4'd6, 16'hC0DE);
      #1 chk("lock_req_ready", 32'(bus4.O_REQ_READY), 32'h4);
      cyc();
      req4(2, 1'b0, 1'b0, 4'd6, 16'hC0DE);
      #1;
      chk("lock_locked", 32'(bus4.O_LOCKED), 32'h1);
      chk("lock_en", 32'(bus4.O_WR_EN), 32'h0040);
      chk("lock_ready_owner", 32'(bus4.O_REQ_READY), 32'h4);
      repeat (2) begin
         cyc(); #1;
         chk("lock_idle_locked", 32'(bus4.O_LOCKED), 32'h1);
         chk("lock_idle_ready", 32'(bus4.O_REQ_READY), 32'h4);
         chk("lock_idle_en", 32'(bus4.O_WR_EN), 32'h0);
      end
      req4(2, 1'b1, 1'b0, 4'd7, 16'hC0DF);
      req4(3, 1'b1, 1'b0, 4'd7, 16'hA003);
      #1 chk("unlock_ready", 32'(bus4.O_REQ_READY), 32'h4);
      cyc();
      req4(2, 1'b0, 1'b0, 4'd7, 16'hC0DF);
      #1;
      chk("unlock_locked", 32'(bus4.O_LOCKED), 32'h0);
      chk("unlock_data", 32'(bus4.O_WR_DATA), 32'hC0DF);
      chk("unlock_next_ready", 32'(bus4.O_REQ_READY), 32'h8);
      cyc();
      req4(3, 1'b0, 1'b0, 4'd7, 16'hA003);
      #1;
      chk("after_unlock_gid", 32'(bus4.O_GRANT_ID), 32'd3);
      cyc();
      bus4.I_REQ_VALID = '0;

      // back-to-back writes to the same register from two sources
      req4(1, 1'b1, 1'b0, 4'd9, 16'h1111);
      req4(3, 1'b1, 1'b0, 4'd9, 16'h3333);
      #1 chk("same_ready", 32'(bus4.O_REQ_READY), 32'h2);
      cyc();
      req4(1, 1'b0, 1'b0, 4'd9, 16'h1111);
      #1;
      chk("same_en1", 32'(bus4.O_WR_EN), 32'h0200);
      chk("same_data1", 32'(bus4.O_WR_DATA), 32'h1111);
      cyc();
      bus4.I_REQ_VALID = '0;
      #1;
      chk("same_en2", 32'(bus4.O_WR_EN), 32'h0200);
      chk("same_data2", 32'(bus4.O_WR_DATA), 32'h3333);

      // three requesters: pointer 2, only req0 valid, top register
      req3(1, 1'b1, 4'd0, 16'h1111);
      #1 chk("n3_first_ready", 32'(bus3.O_REQ_READY), 32'h2);
      cyc();
      bus3.I_REQ_VALID = '0;
      req3(0, 1'b1, 4'd15, 16'h5A5A);
      #1 chk("n3_wrap_ready", 32'(bus3.O_REQ_READY), 32'h1);
      cyc();
      bus3.I_REQ_VALID = '0;
      #1;
      chk("n3_wrap_en", 32'(bus3.O_WR_EN), 32'h8000);
      chk("n3_wrap_gid", 32'(bus3.O_GRANT_ID), 32'd0);
      chk("n3_wrap_data", 32'(bus3.O_WR_DATA), 32'h5A5A);

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
